// File: rtl/sym_answer_tracker.sv
// Symbol/answer tracker: counts target symbols during a level, collects the player's guess
// from debounced-free synchronised buttons, and scores |guess - count| on entry to the post period.
module sym_answer_tracker #(
  parameter int CNT_W     = 7,
  parameter int MAX_GUESS = 99
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             prelimPeriod,
  input  logic             answerPeriod,
  input  logic             postPeriod,
  input  logic             levelChng,
  input  logic             loss,
  input  logic             symValid,
  input  logic             symIsTarget,
  input  logic             btnInc,
  input  logic             btnDec,
  output logic [CNT_W-1:0] symCountDiff,
  output logic [CNT_W-1:0] guess,
  output logic [CNT_W-1:0] targetCount,
  output logic             diffValid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRELIM = 3'd1,
    COUNT  = 3'd2,
    ANSWER = 3'd3,
    SCORE  = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_GUESS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt, guess_nxt, diff_nxt;
  logic             inc_s1, inc_s2, inc_prev;
  logic             dec_s1, dec_s2, dec_prev;
  logic             inc_edge, dec_edge;

  assign inc_edge = inc_s2 & ~inc_prev;
  assign dec_edge = dec_s2 & ~dec_prev;

  // Button synchronisers freeze with the rest of the state while the game is lost.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      inc_s1   <= 1'b0;
      inc_s2   <= 1'b0;
      inc_prev <= 1'b0;
      dec_s1   <= 1'b0;
      dec_s2   <= 1'b0;
      dec_prev <= 1'b0;
    end else if (!loss) begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the
      // synchroniser chain shifts by exactly one stage per clock regardless of statement order.
      inc_s1   <= btnInc;
      inc_s2   <= inc_s1;
      inc_prev <= inc_s2;
      dec_s1   <= btnDec;
      dec_s2   <= dec_s1;
      dec_prev <= dec_s2;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_nxt = state;
    count_nxt = targetCount;
    guess_nxt = guess;
    diff_nxt  = symCountDiff;
    diffValid = 1'b0;

    if (loss) begin
      state_nxt = state;
    end else if (levelChng) begin
      count_nxt = '0;
      guess_nxt = '0;
      state_nxt = prelimPeriod ? PRELIM : COUNT;
    end else begin
      unique case (state)
        IDLE: if (prelimPeriod) state_nxt = PRELIM;
        PRELIM: begin
          if (!prelimPeriod && !answerPeriod && !postPeriod) state_nxt = COUNT;
        end
        COUNT: begin
          if (symValid && symIsTarget && targetCount < MAX_V) count_nxt = targetCount + 1'b1;
          if (answerPeriod)    state_nxt = ANSWER;
          else if (postPeriod) state_nxt = SCORE;
        end
        ANSWER: begin
          if (inc_edge && !dec_edge && guess < MAX_V)    guess_nxt = guess + 1'b1;
          if (dec_edge && !inc_edge && guess != '0)      guess_nxt = guess - 1'b1;
          // A falling answerPeriod with no other phase flag means the answer window closed.
          if (postPeriod || (!answerPeriod && !prelimPeriod)) state_nxt = SCORE;
        end
        SCORE: begin
          diff_nxt  = (guess >= targetCount) ? guess - targetCount : targetCount - guess;
          diffValid = 1'b1;
          state_nxt = HOLD;
        end
        HOLD: if (prelimPeriod) state_nxt = PRELIM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      targetCount  <= '0;
      guess        <= '0;
      symCountDiff <= '0;
    end else begin
      state        <= state_nxt;
      targetCount  <= count_nxt;
      guess        <= guess_nxt;
      symCountDiff <= diff_nxt;
    end
  end

endmodule

// File: tb/tb_sym_answer_tracker.sv
// Directed bench for sym_answer_tracker; score results go through an expected-value queue
// checked by an independent monitor, register values are checked inline.
module tb_sym_answer_tracker;

  localparam int CNT_W = 7;

  logic             Clk = 1'b0;
  logic             reset = 1'b1;
  logic             prelimPeriod = 1'b0, answerPeriod = 1'b0, postPeriod = 1'b0;
  logic             levelChng = 1'b0, loss = 1'b0;
  logic             symValid = 1'b0, symIsTarget = 1'b0;
  logic             btnInc = 1'b0, btnDec = 1'b0;
  logic [CNT_W-1:0] symCountDiff, guess, targetCount;
  logic             diffValid;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int pend_exp;
  bit pending = 1'b0;

  sym_answer_tracker #(.CNT_W(CNT_W), .MAX_GUESS(99)) dut (
    .Clk(Clk), .reset(reset),
    .prelimPeriod(prelimPeriod), .answerPeriod(answerPeriod), .postPeriod(postPeriod),
    .levelChng(levelChng), .loss(loss),
    .symValid(symValid), .symIsTarget(symIsTarget),
    .btnInc(btnInc), .btnDec(btnDec),
    .symCountDiff(symCountDiff), .guess(guess), .targetCount(targetCount),
    .diffValid(diffValid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: a diffValid pulse pops an expectation; the following cycle must show the
  // scored value and a deasserted pulse.
  always @(negedge Clk) begin
    if (!reset) begin
      if (pending) begin
        check("score_value", int'(symCountDiff), pend_exp);
        check("pulse_width", int'(diffValid), 0);
        pending = 1'b0;
      end else if (diffValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          pend_exp = exp_q.pop_front();
          pending  = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input logic inc, input logic dec);
    btnInc = inc;
    btnDec = dec;
    cyc(3);
    btnInc = 1'b0;
    btnDec = 1'b0;
    cyc(3);
  endtask

  task automatic strobe(input logic tgt);
    symValid    = 1'b1;
    symIsTarget = tgt;
    cyc(1);
    symValid    = 1'b0;
    symIsTarget = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rst_guess", int'(guess), 0);
    check("rst_count", int'(targetCount), 0);
    check("rst_diff", int'(symCountDiff), 0);
    check("rst_valid", int'(diffValid), 0);

    // Level 1: prelim, then count 5 targets among 8 strobes.
    prelimPeriod = 1'b1;
    cyc(2);
    prelimPeriod = 1'b0;
    cyc(1);
    press(1'b1, 1'b0);
    check("count_phase_btn", int'(guess), 0);
    strobe(1); strobe(1); strobe(0); strobe(1);
    strobe(0); strobe(1); strobe(0); strobe(1);
    check("count_5", int'(targetCount), 5);

    answerPeriod = 1'b1;
    cyc(1);
    strobe(1);
    check("answer_phase_sym", int'(targetCount), 5);
    repeat (3) press(1'b0, 1'b1);
    check("dec_floor", int'(guess), 0);
    repeat (7) press(1'b1, 1'b0);
    check("guess_7", int'(guess), 7);
    press(1'b1, 1'b1);
    check("inc_dec_same", int'(guess), 7);

    exp_q.push_back(2);
    postPeriod   = 1'b1;
    answerPeriod = 1'b0;
    cyc(4);
    postPeriod = 1'b0;
    cyc(2);
    check("hold_diff", int'(symCountDiff), 2);

    // Level 2: levelChng beats a simultaneous target strobe; guess saturates at 99.
    levelChng   = 1'b1;
    symValid    = 1'b1;
    symIsTarget = 1'b1;
    cyc(1);
    levelChng   = 1'b0;
    symValid    = 1'b0;
    symIsTarget = 1'b0;
    cyc(1);
    check("lvl_clr_count", int'(targetCount), 0);
    check("lvl_clr_guess", int'(guess), 0);
    strobe(1); strobe(1); strobe(1);
    check("count_3", int'(targetCount), 3);
    answerPeriod = 1'b1;
    cyc(1);
    repeat (110) press(1'b1, 1'b0);
    check("inc_ceiling", int'(guess), 99);
    exp_q.push_back(96);
    answerPeriod = 1'b0;
    cyc(4);
    check("hold_diff_96", int'(symCountDiff), 96);

    // Level 3: loss freezes everything.
    levelChng = 1'b1;
    cyc(1);
    levelChng = 1'b0;
    cyc(1);
    strobe(1); strobe(1);
    answerPeriod = 1'b1;
    cyc(1);
    press(1'b1, 1'b0);
    check("pre_loss_guess", int'(guess), 1);
    loss = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btnInc      = i[0];
      btnDec      = i[1];
      symValid    = 1'b1;
      symIsTarget = 1'b1;
      postPeriod  = i[2];
      levelChng   = i[0] & i[1];
      cyc(1);
      check("loss_guess", int'(guess), 1);
      check("loss_count", int'(targetCount), 2);
      check("loss_diff", int'(symCountDiff), 96);
    end
    btnInc = 1'b0; btnDec = 1'b0; symValid = 1'b0; symIsTarget = 1'b0;
    postPeriod = 1'b0; levelChng = 1'b0;
    cyc(1);
    loss = 1'b0;
    cyc(2);
    check("post_loss_guess", int'(guess), 1);
    repeat (3) press(1'b1, 1'b0);
    check("guess_4", int'(guess), 4);

    // Asynchronous reset mid-ANSWER.
    #2 reset = 1'b1;
    #1;
    check("arst_guess", int'(guess), 0);
    check("arst_count", int'(targetCount), 0);
    check("arst_diff", int'(symCountDiff), 0);
    check("arst_valid", int'(diffValid), 0);
    check("arst_state", int'(dut.state), 0);
    answerPeriod = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(4);
    check("arst_state_idle", int'(dut.state), 0);
    check("sb_empty", exp_q.size(), 0);
    check("sb_pending", int'(pending), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
